// File: rtl/common_buffer_pkg.sv
// Shared helpers for the common buffer family: width math and occupancy mode encoding.
package common_buffer_pkg;

   typedef enum logic [1:0] {
      MODE_EMPTY   = 2'd0,
      MODE_PARTIAL = 2'd1,
      MODE_FULL    = 2'd2
   } buf_mode_e;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v = value - 1;
      while (v > 0) begin
         result = result + 1;
         v = v >> 1;
      end
      return result;
   endfunction

   // Pointer width never collapses to zero bits, even for a single-entry buffer.
   function automatic int ptr_w(input int depth);
      return (clog2(depth) < 1) ? 1 : clog2(depth);
   endfunction

   function automatic int cnt_w(input int depth);
      return clog2(depth + 1);
   endfunction

endpackage

// File: rtl/common_bypass_fifo_mem.sv
// DEPTH-entry register file: one synchronous write port, one asynchronous read port, no data reset.
module common_bypass_fifo_mem #(
   parameter int BUFFER_WIDTH = 1,
   parameter int DEPTH        = 2,
   parameter int AW           = 1
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [AW-1:0]           waddr,
   input  logic [BUFFER_WIDTH-1:0] wdata,
   input  logic [AW-1:0]           raddr,
   output logic [BUFFER_WIDTH-1:0] rdata
);

   // Array is padded to the full address space so the read index is always in range.
   logic [BUFFER_WIDTH-1:0] entry_q [2**AW];

   for (genvar i = 0; i < 2**AW; i++) begin : g_entry
      if (i < DEPTH) begin : g_real
         logic entry_we;
         assign entry_we = we && (waddr == AW'(i));
         stdmacro_dffe #(.WIDTH(BUFFER_WIDTH)) u_entry (
            .clk (clk),
            .en  (entry_we),
            .d   (wdata),
            .q   (entry_q[i])
         );
      end else begin : g_pad
         assign entry_q[i] = '0;
      end
   end

   assign rdata = entry_q[raddr];

endmodule

// File: rtl/stdmacro_dffe.sv
// Enable flops: plain variant for payload storage, async active-low reset variant for control.
module stdmacro_dffe #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (en) q <= d;
   end

endmodule

module stdmacro_dffe_ar #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  q <= '0;
      else if (en) q <= d;
   end

endmodule

// File: rtl/common_bypass_fifo.sv
// Multi-entry bypass FIFO: zero-latency pass-through when empty, in-order storage under back-pressure.
module common_bypass_fifo
   import common_buffer_pkg::*;
#(
   parameter int BUFFER_WIDTH = 1,
   parameter int DEPTH        = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [BUFFER_WIDTH-1:0]   prev_i_data,
   input  logic                      prev_i_valid,
   output logic                      prev_o_ready,
   output logic [BUFFER_WIDTH-1:0]   next_o_data,
   output logic                      next_o_valid,
   input  logic                      next_i_ready,
   input  logic                      i_flush,
   output logic [cnt_w(DEPTH)-1:0]   o_count,
   output logic                      o_empty,
   output logic                      o_full
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]           count_q, count_d;
   logic [BUFFER_WIDTH-1:0] mem_rdata;
   buf_mode_e               mode;
   logic                    push, pop, mem_we, drain, state_en;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      mode = MODE_PARTIAL;
      if (count_q == '0)                mode = MODE_EMPTY;
      else if (count_q == CW'(DEPTH))   mode = MODE_FULL;
   end

   assign o_empty = (mode == MODE_EMPTY);
   assign o_full  = (mode == MODE_FULL);
   assign o_count = count_q;

   // Ready is independent of next_i_ready, so no ready-to-ready combinational path exists.
   assign prev_o_ready = ~o_full & ~i_flush & reset;
   assign next_o_data  = o_empty ? prev_i_data : mem_rdata;
   assign next_o_valid = (o_empty ? prev_i_valid : 1'b1) & ~i_flush & reset;

   assign push = prev_i_valid & prev_o_ready;
   assign pop  = next_o_valid & next_i_ready;

   // Once anything is stored, every push goes through storage so older beats drain first.
   assign mem_we   = push & ~(o_empty & pop);
   assign drain    = pop & ~o_empty;
   assign state_en = i_flush | mem_we | drain;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (i_flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (mem_we) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (drain)  rd_ptr_d = ptr_inc(rd_ptr_q);
         case ({mem_we, drain})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   stdmacro_dffe_ar #(.WIDTH(PW)) u_rd_ptr (
      .clk   (clk),
      .rst_n (reset),
      .en    (state_en),
      .d     (rd_ptr_d),
      .q     (rd_ptr_q)
   );

   stdmacro_dffe_ar #(.WIDTH(PW)) u_wr_ptr (
      .clk   (clk),
      .rst_n (reset),
      .en    (state_en),
      .d     (wr_ptr_d),
      .q     (wr_ptr_q)
   );

   stdmacro_dffe_ar #(.WIDTH(CW)) u_count (
      .clk   (clk),
      .rst_n (reset),
      .en    (state_en),
      .d     (count_d),
      .q     (count_q)
   );

   common_bypass_fifo_mem #(
      .BUFFER_WIDTH (BUFFER_WIDTH),
      .DEPTH        (DEPTH),
      .AW           (PW)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wr_ptr_q),
      .wdata (prev_i_data),
      .raddr (rd_ptr_q),
      .rdata (mem_rdata)
   );

endmodule
